rf_bypass_sb: RTL and testbench
===============================

Name: rf_bypass_sb

Overview:
Parametrised multi-register file for the pipelined datapath. It has two combinational read ports and one write port. Optional write-to-read bypass and an optional hardwired-zero register 0 are selectable by parameter. It also keeps a per-register busy scoreboard (set at issue, cleared at writeback, bulk-cleared on flush), which decode uses to detect RAW hazards. It replaces the fixed 8x16 register file in the decode stage.

Parameters:
WIDTH, 16, data width of each register in bits
DEPTH, 8, number of registers; power of two, 2..32
AW, 3, select width; must equal log2(DEPTH)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, and is never busy

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
read1regsel  in  AW  read port 1 register select
read2regsel  in  AW  read port 2 register select
read1data  out  WIDTH  read port 1 data (combinational)
read2data  out  WIDTH  read port 2 data (combinational)
read1busy  out  1  selected register 1 has a pending producer
read2busy  out  1  selected register 2 has a pending producer
writeregsel  in  AW  write register select
writedata  in  WIDTH  write data
write  in  1  write enable; also clears the busy bit of writeregsel
issue  in  1  mark issueregsel busy (producer instruction issued)
issueregsel  in  AW  register whose busy bit is set
flush  in  1  clear all busy bits (pipeline squash)
busyany  out  1  OR of all busy bits (registered state)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers = 0; all busy bits = 0.
  - Outputs therefore read 0, busy 0, busyany 0 while reset is held and after release.
  - Reset asserted mid-write or mid-issue: that update is lost; state is 0 on the next edge after release.
- Write: on the rising edge with write=1, reg[writeregsel] <= writedata. Exception: with ZERO_REG=1 and writeregsel=0, the write is ignored.
- Read, per port n:
  - BYPASS=1, write=1, writeregsel==readNregsel (and not the ZERO_REG register 0): readNdata = writedata in the same cycle.
  - Otherwise: readNdata = reg[readNregsel].
  - ZERO_REG=1 and readNregsel=0: readNdata = 0 always, bypass included.
  - Both ports may select the same register; both return identical data.
- Busy scoreboard, per register i, next-state priority on each edge:
  1. flush=1: busy[i] <= 0 for all i. A simultaneous issue is dropped.
  2. issue=1 and issueregsel==i: busy[i] <= 1. This wins over a simultaneous write to i, because a new producer supersedes the old one.
  3. write=1 and writeregsel==i: busy[i] <= 0.
  4. Otherwise busy[i] holds.
  - ZERO_REG=1: busy[0] is forced to 0, and issue to register 0 is ignored.
- readNbusy = busy[readNregsel] from registered state, except:
  - with BYPASS=1, when write=1 to the same register, readNbusy = 0, because the data is being forwarded this cycle;
  - with BYPASS=0, readNbusy reflects only registered state.
- busyany = OR of the registered busy bits; it does not look ahead to same-cycle updates.
- Latency:
  - write to stored-read: 1 cycle;
  - write to bypass-read: 0 cycles;
  - issue to busy visible: 1 cycle.
- Select wrap: the select is exactly AW bits and DEPTH = 2^AW, so no out-of-range selects exist.
- No X propagation: unused bypass paths must be gated, not left undriven.

Test Plan:
1. Reset + basic write/read: reset, write 0xBEEF to r5, write 0x1234 to r2, read1regsel=5, read2regsel=2 -> next cycle read1data=0xBEEF, read2data=0x1234; all other registers read 0.
2. Bypass (BYPASS=1): write=1, writeregsel=3, writedata=0xA5A5, read1regsel=3 in the same cycle -> read1data=0xA5A5 and read1busy=0 that cycle.
   Repeat with BYPASS=0 -> read1data returns the old value (0).
3. Scoreboard lifecycle:
   - issue r4 -> next cycle read2busy=1 (read2regsel=4) and busyany=1;
   - write r4 with 0x0007 -> next cycle read2busy=0, busyany=0, read2data=0x0007.
4. Simultaneous events:
   - issue r6 and write r6 in the same cycle -> r6 data updated, busy[6]=1;
   - issue r1 with flush=1 -> all busy=0, r1 not busy.
5. ZERO_REG=1, DEPTH=16, WIDTH=32:
   - write r0 with 0xFFFFFFFF and issue r0 -> read1data=0, read1busy=0;
   - write r15 with 0xDEADBEEF -> reads back 0xDEADBEEF.
6. Async reset mid-operation: write r7=0x55AA, assert rst_n=0 between clock edges -> read data and busy bits go to 0 immediately, and remain 0 after release with no write.

Source files
------------

// File: rtl/rf_bypass_sb_if.sv
// Register-file port bundle: read, write, issue and flush signals shared by decode and writeback.
// The master drives selects and commands; the slave returns read data and busy status.
interface rf_bypass_sb_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [AW-1:0]    read1regsel;
    logic [AW-1:0]    read2regsel;
    logic [WIDTH-1:0] read1data;
    logic [WIDTH-1:0] read2data;
    logic             read1busy;
    logic             read2busy;
    logic [AW-1:0]    writeregsel;
    logic [WIDTH-1:0] writedata;
    logic             write;
    logic             issue;
    logic [AW-1:0]    issueregsel;
    logic             flush;
    logic             busyany;

    modport master (
        output read1regsel, read2regsel, writeregsel, writedata, write,
               issue, issueregsel, flush,
        input  read1data, read2data, read1busy, read2busy, busyany
    );

    modport slave (
        input  read1regsel, read2regsel, writeregsel, writedata, write,
               issue, issueregsel, flush,
        output read1data, read2data, read1busy, read2busy, busyany
    );
endinterface

// File: rtl/rf_bypass_sb.sv
// Register file with two combinational read ports, one write port, optional write-to-read
// bypass, optional hardwired-zero r0, and a per-register busy scoreboard for RAW detection.
module rf_bypass_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input logic          clk,
    input logic          rst_n,
    rf_bypass_sb_if.slave rf
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic wr_zero;
    logic iss_zero;
    logic zero1, zero2;
    logic hit1, hit2;

    always_comb begin
        wr_zero  = (ZERO_REG != 0) && (rf.writeregsel == '0);
        iss_zero = (ZERO_REG != 0) && (rf.issueregsel == '0);
        regs_d   = regs_q;
        if (rf.write && !wr_zero) begin
            regs_d[rf.writeregsel] = rf.writedata;
        end
    end

    // Issue is applied after write so a new producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (rf.flush) begin
            busy_d = '0;
        end else begin
            if (rf.write) begin
                busy_d[rf.writeregsel] = 1'b0;
            end
            if (rf.issue && !iss_zero) begin
                busy_d[rf.issueregsel] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Forwarding hits are gated off entirely when the bypass is not built in.
    always_comb begin
        zero1 = (ZERO_REG != 0) && (rf.read1regsel == '0);
        zero2 = (ZERO_REG != 0) && (rf.read2regsel == '0);
        hit1  = (BYPASS != 0) && rf.write && (rf.writeregsel == rf.read1regsel);
        hit2  = (BYPASS != 0) && rf.write && (rf.writeregsel == rf.read2regsel);
    end

    assign rf.read1data = zero1 ? '0 : (hit1 ? rf.writedata : regs_q[rf.read1regsel]);
    assign rf.read2data = zero2 ? '0 : (hit2 ? rf.writedata : regs_q[rf.read2regsel]);
    assign rf.read1busy = !zero1 && !hit1 && busy_q[rf.read1regsel];
    assign rf.read2busy = !zero2 && !hit2 && busy_q[rf.read2regsel];
    assign rf.busyany   = |busy_q;

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Scoreboard bench for rf_bypass_sb: three configurations share one stimulus stream and are
// checked each cycle against a behavioural register-file model.
module tb_rf_bypass_sb;

    typedef struct packed {
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  ws;
        logic [3:0]  is;
        logic [31:0] wd;
        logic        we;
        logic        iss;
        logic        fl;
    } stim_t;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        any;
    } exp_t;

    logic clk;
    logic rst_n;

    rf_bypass_sb_if #(.WIDTH(16), .AW(3)) ifa ();
    rf_bypass_sb_if #(.WIDTH(16), .AW(3)) ifb ();
    rf_bypass_sb_if #(.WIDTH(32), .AW(4)) ifc ();

    rf_bypass_sb #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1), .ZERO_REG(0))
        dut_a (.clk(clk), .rst_n(rst_n), .rf(ifa));
    rf_bypass_sb #(.WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(0), .ZERO_REG(0))
        dut_b (.clk(clk), .rst_n(rst_n), .rf(ifb));
    rf_bypass_sb #(.WIDTH(32), .DEPTH(16), .AW(4), .BYPASS(1), .ZERO_REG(1))
        dut_c (.clk(clk), .rst_n(rst_n), .rf(ifc));

    int          cfg_depth [3] = '{8, 8, 16};
    logic [31:0] cfg_mask  [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF};
    bit          cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};
    bit          cfg_zero  [3] = '{1'b0, 1'b0, 1'b1};

    logic [31:0] m_reg  [3][16];
    bit          m_busy [3][16];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [32:0] port_read(int k, int sel, stim_t s);
        int ws;
        ws = int'(s.ws) & (cfg_depth[k] - 1);
        if (cfg_zero[k] && sel == 0) return 33'd0;
        if (cfg_byp[k] && s.we && ws == sel) return {1'b0, s.wd & cfg_mask[k]};
        return {m_busy[k][sel], m_reg[k][sel]};
    endfunction

    function automatic exp_t predict(int k, stim_t s);
        exp_t e;
        logic [32:0] p1, p2;
        p1 = port_read(k, int'(s.r1) & (cfg_depth[k] - 1), s);
        p2 = port_read(k, int'(s.r2) & (cfg_depth[k] - 1), s);
        e.d1  = p1[31:0];
        e.b1  = p1[32];
        e.d2  = p2[31:0];
        e.b2  = p2[32];
        e.any = 1'b0;
        for (int i = 0; i < cfg_depth[k]; i++) e.any = e.any | m_busy[k][i];
        return e;
    endfunction

    task automatic model_update(int k, stim_t s);
        int ws, is;
        ws = int'(s.ws) & (cfg_depth[k] - 1);
        is = int'(s.is) & (cfg_depth[k] - 1);
        if (s.we && !(cfg_zero[k] && ws == 0)) m_reg[k][ws] = s.wd & cfg_mask[k];
        for (int i = 0; i < cfg_depth[k]; i++) begin
            if (s.fl) m_busy[k][i] = 1'b0;
            else if (s.iss && is == i && !(cfg_zero[k] && i == 0)) m_busy[k][i] = 1'b1;
            else if (s.we && ws == i) m_busy[k][i] = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) begin
                m_reg[k][i]  = 32'd0;
                m_busy[k][i] = 1'b0;
            end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(stim_t s);
        ifa.read1regsel = s.r1[2:0]; ifa.read2regsel = s.r2[2:0];
        ifa.writeregsel = s.ws[2:0]; ifa.issueregsel = s.is[2:0];
        ifa.writedata = s.wd[15:0]; ifa.write = s.we; ifa.issue = s.iss; ifa.flush = s.fl;
        ifb.read1regsel = s.r1[2:0]; ifb.read2regsel = s.r2[2:0];
        ifb.writeregsel = s.ws[2:0]; ifb.issueregsel = s.is[2:0];
        ifb.writedata = s.wd[15:0]; ifb.write = s.we; ifb.issue = s.iss; ifb.flush = s.fl;
        ifc.read1regsel = s.r1; ifc.read2regsel = s.r2;
        ifc.writeregsel = s.ws; ifc.issueregsel = s.is;
        ifc.writedata = s.wd; ifc.write = s.we; ifc.issue = s.iss; ifc.flush = s.fl;
    endtask

    task automatic push_all(stim_t s);
        q0.push_back(predict(0, s));
        q1.push_back(predict(1, s));
        q2.push_back(predict(2, s));
    endtask

    task automatic step(stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        push_all(s);
        for (int k = 0; k < 3; k++) model_update(k, s);
    endtask

    task automatic rst_step(stim_t s);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        drive(s);
        push_all(s);
    endtask

    function automatic stim_t rd(logic [3:0] r1, logic [3:0] r2);
        stim_t s;
        s = '0;
        s.r1 = r1;
        s.r2 = r2;
        return s;
    endfunction

    // ---------------- monitor ----------------
    task automatic check_one(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %h expected %h at %0t", k, name, act, exp, $time);
        end
    endtask

    task automatic compare(int k, exp_t e, logic [31:0] d1, logic [31:0] d2,
                           logic b1, logic b2, logic any);
        check_one("read1data", k, d1, e.d1);
        check_one("read2data", k, d2, e.d2);
        check_one("read1busy", k, {31'd0, b1}, {31'd0, e.b1});
        check_one("read2busy", k, {31'd0, b2}, {31'd0, e.b2});
        check_one("busyany",   k, {31'd0, any}, {31'd0, e.any});
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0)
            compare(0, q0.pop_front(), {16'd0, ifa.read1data}, {16'd0, ifa.read2data},
                    ifa.read1busy, ifa.read2busy, ifa.busyany);
        if (q1.size() > 0)
            compare(1, q1.pop_front(), {16'd0, ifb.read1data}, {16'd0, ifb.read2data},
                    ifb.read1busy, ifb.read2busy, ifb.busyany);
        if (q2.size() > 0)
            compare(2, q2.pop_front(), ifc.read1data, ifc.read2data,
                    ifc.read1busy, ifc.read2busy, ifc.busyany);
    end

    // ---------------- test sequence ----------------
    initial begin
        stim_t s;
        rst_n = 1'b0;
        model_clear();
        drive('0);

        rst_step(rd(4'd5, 4'd2));
        rst_step(rd(4'd0, 4'd7));
        step(rd(4'd5, 4'd2));
        rst_n = 1'b1;

        // basic write/read
        s = rd(4'd5, 4'd2); s.we = 1; s.ws = 4'd5; s.wd = 32'h0000_BEEF; step(s);
        s = rd(4'd5, 4'd2); s.we = 1; s.ws = 4'd2; s.wd = 32'h0000_1234; step(s);
        step(rd(4'd5, 4'd2));
        step(rd(4'd1, 4'd3));

        // same-cycle bypass
        s = rd(4'd3, 4'd5); s.we = 1; s.ws = 4'd3; s.wd = 32'h0000_A5A5; step(s);
        step(rd(4'd3, 4'd3));

        // scoreboard lifecycle
        s = rd(4'd0, 4'd4); s.iss = 1; s.is = 4'd4; step(s);
        step(rd(4'd1, 4'd4));
        s = rd(4'd1, 4'd4); s.we = 1; s.ws = 4'd4; s.wd = 32'h0000_0007; step(s);
        step(rd(4'd1, 4'd4));

        // simultaneous issue+write, then issue under flush
        s = rd(4'd6, 4'd1); s.iss = 1; s.is = 4'd6; s.we = 1; s.ws = 4'd6; s.wd = 32'h0000_0066; step(s);
        step(rd(4'd6, 4'd1));
        s = rd(4'd6, 4'd1); s.iss = 1; s.is = 4'd1; s.fl = 1; step(s);
        step(rd(4'd6, 4'd1));

        // register 0 and top register
        s = rd(4'd0, 4'd0); s.we = 1; s.ws = 4'd0; s.wd = 32'hFFFF_FFFF; s.iss = 1; s.is = 4'd0; step(s);
        step(rd(4'd0, 4'd0));
        s = rd(4'd15, 4'd0); s.we = 1; s.ws = 4'd15; s.wd = 32'hDEAD_BEEF; step(s);
        step(rd(4'd15, 4'd7));

        // asynchronous reset between edges, with an issue pending while held
        s = rd(4'd7, 4'd0); s.we = 1; s.ws = 4'd7; s.wd = 32'h0000_55AA; s.iss = 1; s.is = 4'd7; step(s);
        step(rd(4'd7, 4'd15));
        s = rd(4'd7, 4'd15); s.iss = 1; s.is = 4'd7; rst_step(s);
        rst_step(rd(4'd7, 4'd15));
        step(rd(4'd7, 4'd15));
        rst_n = 1'b1;
        step(rd(4'd7, 4'd15));
        step(rd(4'd7, 4'd15));

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            s.r1  = 4'($urandom_range(0, 15));
            s.r2  = 4'($urandom_range(0, 15));
            s.ws  = 4'($urandom_range(0, 15));
            s.is  = ($urandom_range(0, 3) == 0) ? s.ws : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) s.r1 = s.ws;
            s.wd  = $urandom;
            s.we  = ($urandom_range(0, 1) == 1);
            s.iss = ($urandom_range(0, 2) == 0);
            s.fl  = ($urandom_range(0, 15) == 0);
            step(s);
        end

        step(rd(4'd0, 4'd0));
        repeat (3) @(posedge clk);
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size() + q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
